debug_trace_ctrl: RTL
=====================

# debug_trace_ctrl

Trigger-driven capture controller for the CPU debug path. Watches the per-commit debug event stream (PC, instruction, cycle stamp, cache-miss/branch/stall flags) and arms on a host pulse. On a trigger (PC match or first event) it captures the trigger event plus a programmable number of following events into a small FIFO. It drains that FIFO to the debug print/trace sink over a valid/ready handshake, so the sink sees a bounded window around the point of interest instead of every commit.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- ADDR_W, 3: log2(DEPTH).
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  commit event present this cycle.
- in_pc  in  64  event PC.
- in_instr  in  32  event instruction word.
- in_miss / in_branch / in_stall  in  1 each  event flags.
- cycle  in  64  free-running cycle counter from core; sampled at capture.
- arm  in  1  single-cycle arm request.
- trig_en  in  1  1 = trigger on PC match, 0 = trigger on first event after arming.
- trig_pc  in  64  trigger PC.
- post_count  in  8  events captured after the trigger event.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  sink accepts head.
- out_pc / out_instr / out_cycle  out  64/32/64  head fields.
- out_miss / out_branch / out_stall  out  1 each  head flags.
- state  out  2  controller state encoding.
- level  out  ADDR_W+1  FIFO occupancy, 0..DEPTH.
- dropped  out  16  events lost to FIFO full; saturates at 0xFFFF.

## Operation
- States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE: no capture. arm=1 → ARMED; dropped cleared to 0.
- ARMED: trigger = in_valid & (!trig_en | in_pc==trig_pc). The trigger event is pushed and remaining is loaded with post_count. With post_count==0 → DONE; otherwise → CAPTURE.
- CAPTURE: every in_valid is pushed and remaining decrements. The push with remaining==1 → DONE. Total window = 1 + post_count events.
- DONE: no capture. arm=1 → ARMED and clears dropped. FIFO contents are kept and continue draining.
- arm in ARMED or CAPTURE is ignored.
- Push record: {in_pc, in_instr, cycle, in_miss, in_branch, in_stall}, all sampled in the push cycle.
- Full rule:
  - A push while level==DEPTH with no pop in the same cycle is discarded and dropped increments (saturating).
  - The discarded event still counts against remaining.
  - Push and pop in the same cycle while full: both succeed and level is unchanged.
- Drain runs in every state: pop = out_valid & out_ready. out_valid = (level != 0). Output fields show the head entry and are held stable while out_valid & !out_ready.
- When empty, out_* data fields drive 0.
- Pointers are ADDR_W bits and wrap modulo DEPTH. level is tracked separately so full and empty are unambiguous.

## Timing
- Reset (async assert, sync release): state=IDLE, level=0, out_valid=0, all out_* data=0, dropped=0, pointers=0, remaining=0. Mid-operation reset discards the FIFO and window immediately.
- Capture latency: event pushed at edge N → out_valid=1 and fields valid after edge N (same cycle N+1). No combinational path from in_* to out_*.
- out_valid depends only on registered level; out_ready has no combinational effect on out_valid in the same cycle.
- State transitions take effect at the edge after the qualifying event; the trigger event itself is captured in that same edge.
- arm and trigger in the same cycle in IDLE: arm only; the event is not captured.

## Test plan
- Basic window: arm, trig_en=0, post_count=3, out_ready=1, 6 consecutive events PC 0x1000..0x1014 → exactly PCs 0x1000,0x1004,0x1008,0x100C emitted in order; state ends DONE; dropped=0.
- PC trigger: trig_en=1, trig_pc=0x2008, post_count=1, events 0x2000..0x2010 → output 0x2008,0x200C only; each out_cycle equals the cycle value at its push.
- Overflow: DEPTH=8, out_ready=0, post_count=11 → 12 captures, level=8, dropped=4, state DONE. Then out_ready=1 → first 8 events drain in order and level returns to 0.
- Full with simultaneous pop: level=8, out_ready=1, push in the same cycle → level stays 8, dropped unchanged, no data lost.
- Backpressure: toggle out_ready 1/0 each cycle during drain → head fields stable while stalled, no duplicates or skips across a wrap of pointers.
- Reset mid-CAPTURE with level=5 → next cycle out_valid=0, level=0, state=IDLE, dropped=0; subsequent in_valid not captured until arm.

Source files
------------

// File: rtl/debug_trace_ctrl.sv
// Trigger-driven debug capture controller: arms on a host pulse, captures a trigger
// event plus post_count followers into a FIFO and drains it over valid/ready.
module debug_trace_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [63:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic              in_miss,
    input  logic              in_branch,
    input  logic              in_stall,
    input  logic [63:0]       cycle,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [63:0]       trig_pc,
    input  logic [7:0]        post_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [63:0]       out_cycle,
    output logic              out_miss,
    output logic              out_branch,
    output logic              out_stall,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       dropped
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [63:0]         r_mem_pc    [DEPTH];
    logic [31:0]         r_mem_instr [DEPTH];
    logic [63:0]         r_mem_cycle [DEPTH];
    logic [2:0]          r_mem_flags [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_level;
    logic [7:0]          r_remaining;
    logic [15:0]         r_dropped;

    logic w_trigger;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_write;
    logic w_drop;
    logic w_rearm;

    assign w_trigger = in_valid & (~trig_en | (in_pc == trig_pc));
    assign w_full    = (r_level == (ADDR_W+1)'(DEPTH));
    assign w_pop     = out_valid & out_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign w_write   = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_rearm   = arm & ((r_state == S_IDLE) | (r_state == S_DONE));

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (w_trigger) begin
                    w_push      = 1'b1;
                    w_state_nxt = (post_count == 8'd0) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    w_push = 1'b1;
                    if (r_remaining <= 8'd1) w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= 8'd0;
            r_dropped   <= 16'd0;
        end else begin
            if (r_state == S_ARMED && w_trigger)
                r_remaining <= post_count;
            else if (r_state == S_CAPTURE && in_valid)
                r_remaining <= r_remaining - 8'd1;

            if (w_rearm)
                r_dropped <= 16'd0;
            else if (w_drop && r_dropped != 16'hFFFF)
                r_dropped <= r_dropped + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_write, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; emptiness is decided by r_level alone.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem_pc[r_wr_ptr]    <= in_pc;
            r_mem_instr[r_wr_ptr] <= in_instr;
            r_mem_cycle[r_wr_ptr] <= cycle;
            r_mem_flags[r_wr_ptr] <= {in_miss, in_branch, in_stall};
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_pc     = out_valid ? r_mem_pc[r_rd_ptr]       : 64'd0;
    assign out_instr  = out_valid ? r_mem_instr[r_rd_ptr]    : 32'd0;
    assign out_cycle  = out_valid ? r_mem_cycle[r_rd_ptr]    : 64'd0;
    assign out_miss   = out_valid & r_mem_flags[r_rd_ptr][2];
    assign out_branch = out_valid & r_mem_flags[r_rd_ptr][1];
    assign out_stall  = out_valid & r_mem_flags[r_rd_ptr][0];
    assign state      = r_state;
    assign level      = r_level;
    assign dropped    = r_dropped;

endmodule
